// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder slice.
//   state_t   : controller FSM encoding (IDLE, RUN, DONE).
//   cnt_width : bit-counter width for a given operand width (min 1).
//   Optional feature macro used by the slice: SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_cell.sv
// full_adder_cell
//   Purely combinational 1-bit full adder shared by the serial controller.
//   Ports:
//     a, b, cin : input bits
//     s         : sum bit   = a ^ b ^ cin
//     cout      : carry out = majority(a, b, cin)
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder. One full_adder_cell is reused over WIDTH
//   cycles, LSB first, with a registered carry between cycles.
//   Parameters:
//     WIDTH : operand/sum width, 1..64
//   Ports:
//     clk   : clock, rising edge
//     rst   : asynchronous active-high reset
//     start : request, accepted only in IDLE or DONE
//     a, b  : operands, captured on accepted start
//     cin   : carry-in, captured on accepted start
//     sub   : (only with SERIAL_ADDER_SUB_EN) subtract select, captured
//             with operands; sub=1 computes a-b, cout=1 means no borrow
//     busy  : high while bits are processed (RUN)
//     done  : one-cycle pulse, s/cout valid
//     s     : sum, held until the next result
//     cout  : final carry-out, held with s
//   Optional feature macro: SERIAL_ADDER_SUB_EN
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             sum_bit;
   logic             carry_next;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] b_load;
   logic             c_load;

   // Operand B / carry as they are loaded; subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
   always_comb begin
      b_load = sub ? ~b   : b;
      c_load = sub ? 1'b1 : cin;
   end
`else
   always_comb begin
      b_load = b;
      c_load = cin;
   end
`endif

   full_adder_cell u_cell (
      .a    (op_a[0]),
      .b    (op_b[0]),
      .cin  (carry),
      .s    (sum_bit),
      .cout (carry_next)
   );

   // Sum shifts right with the new bit entering at the MSB; written as a
   // shift plus bit overwrite so WIDTH=1 needs no special slice.
   always_comb begin
      sum_next            = acc >> 1;
      sum_next[WIDTH-1]   = sum_bit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         op_a  <= '0;
         op_b  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         s     <= '0;
         cout  <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= b_load;
                  carry <= c_load;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               carry <= carry_next;
               acc   <= sum_next;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  s     <= sum_next;
                  cout  <= carry_next;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       cin = 1'b0;
   logic       busy, done, cout;
   logic [7:0] s;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1, done1, cout1;
   logic [0:0] s1;

`ifdef SERIAL_ADDER_SUB_EN
   logic       sub  = 1'b0;
   logic       sub1 = 1'b0;
`endif

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [8:0]  prev8 = '0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .cin   (cin1),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub1),
`endif
      .busy  (busy1),
      .done  (done1),
      .s     (s1),
      .cout  (cout1)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       cout;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain (WIDTH+1)-bit arithmetic.
   function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic subtract);
      logic [8:0] r;
      if (subtract) r = {1'b0, x} + {1'b0, ~y} + 9'd1;
      else          r = {1'b0, x} + {1'b0, y} + {8'd0, c};
      return r;
   endfunction

   // One full transaction on the 8-bit instance with full cycle-by-cycle checks.
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic tsub, input logic [8:0] expv, input string nm);
      @(negedge clk);
      start = 1'b1; a = ta; b = tb; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
      sub = tsub;
`endif
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         chk({nm, ".busy"}, {63'd0, busy}, 64'd1);
         chk({nm, ".nodone"}, {63'd0, done}, 64'd0);
         chk({nm, ".hold"}, {55'd0, cout, s}, {55'd0, prev8});
         // Scramble inputs and poke start while running; all must be ignored.
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         sub = 1'($urandom);
`endif
         start = (k < 8) ? 1'($urandom) : 1'b0;
      end
      @(posedge clk); #1;
      chk({nm, ".done"}, {62'd0, busy, done}, 64'd1);
      chk({nm, ".result"}, {55'd0, cout, s}, {55'd0, expv});
      prev8 = expv;
      @(posedge clk); #1;
      chk({nm, ".idle"}, {62'd0, busy, done}, 64'd0);
      chk({nm, ".held"}, {55'd0, cout, s}, {55'd0, prev8});
   endtask

   task automatic run1(input logic ta, input logic tb, input logic tc);
      @(negedge clk);
      start1 = 1'b1; a1 = ta; b1 = tb; cin1 = tc;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("w1.busy", {62'd0, busy1, done1}, 64'd2);
      @(posedge clk); #1;
      chk("w1.done", {62'd0, busy1, done1}, 64'd1);
      chk("w1.result", {62'd0, cout1, s1}, 64'(ta) + 64'(tb) + 64'(tc));
      @(posedge clk); #1;
      chk("w1.idle", {62'd0, busy1, done1}, 64'd0);
   endtask

   initial begin
      vec_t tbl[4];
      logic [7:0] ra, rb, rec0, rec1;
      logic       rc;
      logic [8:0] r0, r1, exp_sc;

      tbl[0] = '{a: 8'h35, b: 8'h4A, cin: 1'b0, s: 8'h7F, cout: 1'b0};
      tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, cout: 1'b1};
      tbl[2] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, cout: 1'b0};
      tbl[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, cout: 1'b1};

      // Reset state
      #1;
      chk("rst.outs", {53'd0, busy, done, cout, s}, 64'd0);
      chk("rst.outs1", {61'd0, busy1, done1, cout1}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      // Directed table
      for (int i = 0; i < 4; i++)
         run8(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, {tbl[i].cout, tbl[i].s}, $sformatf("tbl%0d", i));

      // Random against the arithmetic model
      for (int i = 0; i < 12; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         run8(ra, rb, rc, 1'b0, model8(ra, rb, rc, 1'b0), $sformatf("rnd%0d", i));
      end

      // Back-to-back with start held high and a changing every cycle
      @(negedge clk);
      start = 1'b1; b = 8'h11; cin = 1'b0; a = 8'($urandom); rec0 = a; rec1 = '0;
      r0 = model8(rec0, 8'h11, 1'b0, 1'b0);
      r1 = '0;
      for (int c = 1; c <= 19; c++) begin
         @(posedge clk); #1;
         if (c == 18) r1 = model8(rec1, 8'h11, 1'b0, 1'b0);
         chk($sformatf("b2b.c%0d.ctl", c), {62'd0, busy, done},
             (c == 9 || c == 18) ? 64'd1 : 64'd2);
         exp_sc = (c < 9) ? prev8 : (c < 18) ? r0 : r1;
         chk($sformatf("b2b.c%0d.res", c), {55'd0, cout, s}, {55'd0, exp_sc});
         a = 8'($urandom);
         if (c == 9) rec1 = a;
      end
      start = 1'b0;
      prev8 = r1;

      // Reset mid-run: abort, clear, no done
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      prev8 = '0;
      run8(8'hC3, 8'h5A, 1'b1, 1'b0, model8(8'hC3, 8'h5A, 1'b1, 1'b0), "pre_abort");
      @(negedge clk);
      start = 1'b1; a = 8'h77; b = 8'h66; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort.clear", {53'd0, busy, done, cout, s}, 64'd0);
      @(posedge clk); #1;
      chk("abort.hold", {53'd0, busy, done, cout, s}, 64'd0);
      @(negedge clk); rst = 1'b0;
      prev8 = '0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("abort.nodone", {62'd0, busy, done}, 64'd0);
      end
      run8(8'h10, 8'h20, 1'b0, 1'b0, {1'b0, 8'h30}, "after_abort");

      // WIDTH=1: full-adder truth table
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         run1(v[2], v[1], v[0]);
      end

`ifdef SERIAL_ADDER_SUB_EN
      run8(8'h10, 8'h01, 1'b0, 1'b1, {1'b1, 8'h0F}, "sub0");
      run8(8'h01, 8'h02, 1'b1, 1'b1, {1'b0, 8'hFF}, "sub1");
      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         run8(ra, rb, rc, 1'b1, model8(ra, rb, rc, 1'b1), $sformatf("subrnd%0d", i));
      end
      run8(8'h35, 8'h4A, 1'b1, 1'b0, {1'b0, 8'h80}, "sub_off");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder. The controller time-multiplexes one combinational 1-bit full-adder cell over WIDTH clock cycles, LSB first, through a registered carry.
- Operands are loaded on a start/done handshake.
- The block shifts them through the cell and accumulates the sum in a shift register.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..64.

Ports:
- clk    input   1      system clock, all state updates on rising edge
- rst    input   1      asynchronous, active-high reset
- start  input   1      request; sampled only in IDLE or DONE
- a      input   WIDTH  operand A, captured on accepted start
- b      input   WIDTH  operand B, captured on accepted start
- cin    input   1      carry-in, captured on accepted start
- busy   output  1      high while bits are being processed (RUN)
- done   output  1      one-cycle pulse: s/cout valid
- s      output  WIDTH  sum, held until next accepted start
- cout   output  1      final carry-out, held with s

Clocking and reset:
- Single clock (clk). Reset (rst) is asynchronous and active-high.

Behaviour:
- Reset state (asynchronous, immediate): state=IDLE, busy=0, done=0, s=0, cout=0, counter=0, carry=0, shift regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1 (accepted). At that edge:
  - op_a<=a, op_b<=b, carry<=cin, counter<=0.
- RUN, each edge:
  - The cell computes sum_bit / carry_next from op_a[0], op_b[0], carry.
  - carry<=carry_next.
  - op_a/op_b shift right by 1.
  - sum reg shifts right with sum_bit entering at MSB.
  - counter++.
- RUN -> DONE on the edge that processes bit WIDTH-1 (counter==WIDTH-1). At that edge, s<=final sum shift value and cout<=carry_next.
- DONE lasts exactly one cycle (done=1).
  - DONE -> RUN if start=1 (back-to-back, new operands captured).
  - DONE -> IDLE otherwise.
- Latency: start high in cycle 0 → busy=1 in cycles 1..WIDTH → done=1 in cycle WIDTH+1. Max throughput is one result per WIDTH+1 cycles.
- busy = (state==RUN); done = (state==DONE), registered-state decode, glitch-free.
- start while RUN: ignored. No queuing, no effect on operands or result.
- a/b/cin changes after capture: ignored.
- s/cout visible values:
  - Stay at the previous result during RUN.
  - Update only at the RUN->DONE edge.
  - Hold through IDLE.
- WIDTH=1: exactly one RUN cycle; the same rules apply.
- Arithmetic: {cout,s} = a + b + cin, modulo 2^(WIDTH+1).
- Reset asserted mid-RUN: aborts immediately, all state cleared, no done pulse; the first start after release behaves normally.
- Counter width: $clog2(WIDTH) bits, min 1.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with operands.
  - If sub=1: op_b<=~b and carry<=1 (cin ignored), giving s=a-b and cout=1 meaning no borrow.
  - If sub=0: behaves as add.
- Undefined: no sub port, always add; cin used as given.

Decomposition:
- Package serial_adder_pkg: state_t enum {IDLE, RUN, DONE}.
- Sub-module full_adder_cell: purely combinational 1-bit full adder.
  - Ports a, b, cin, s, cout.
  - s = a^b^cin; cout = majority(a,b,cin).
  - Instantiated once in the controller.

Test Plan:
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, start one cycle → busy cycles 1..8, done pulse cycle 9, s=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 → s=8'h00, cout=1. Then a=0, b=0, cin=1 → s=8'h01, cout=0.
- Start held high continuously with a changing every cycle:
  - Results match operands captured at cycle 0 and at the DONE cycle (back-to-back).
  - Pulses at cycles 9 and 18.
  - Start during RUN is ignored.
- Assert rst at cycle 4 of a run → busy=0, s=0, cout=0, no done. Then release and run 8'h10+8'h20 → s=8'h30.
- WIDTH=1, all 8 combinations of a/b/cin → {cout,s} equals the full-adder truth table, done at cycle 2 each time.
- With SERIAL_ADDER_SUB_EN: sub=1, a=8'h10, b=8'h01 → s=8'h0F, cout=1. Then a=8'h01, b=8'h02 → s=8'hFF, cout=0.
